operand_collector_4x32: RTL and testbench
=========================================

# operand_collector_4x32

Sequential front-end stage for the 4x32 multi-operand adder. Accepts a serial stream of 32-bit words over a valid/ready handshake and groups them into four operand slots x, y, z and w. Each complete group is presented to the combinational adder on a valid/ready output handshake. A short group can be closed early with a last flag, and the unused slots are zero-filled so the downstream sum stays correct.

## Interface
Parameters:
- DATA_W, 32, operand width; matches adder operand width
- CNT_W, 16, width of the group counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input word available
- in_ready  out  1  collector can accept a word this cycle
- in_data  in  DATA_W  input word
- in_last  in  1  qualifies in_data; closes the current group after this word
- out_valid  out  1  group in x/y/z/w is complete and stable
- out_ready  in  1  downstream consumes group this cycle
- x, y, z, w  out  DATA_W each  operand slots 0..3, registered
- out_count  out  3  number of real operands in the presented group, 1..4
- group_cnt  out  CNT_W  groups handed off since reset, wraps modulo 2^CNT_W

## Operation
- Handshakes:
  - An input word transfers on a cycle with in_valid & in_ready.
  - A group transfers on a cycle with out_valid & out_ready.
- States:
  - COLLECT: out_valid=0, in_ready=1.
  - HOLD: out_valid=1, in_ready=out_ready (combinational pass-through).
- Slot index idx: 2 bits. It selects which slot receives the next accepted word: 0→x, 1→y, 2→z, 3→w.
- COLLECT, word accepted:
  - The word is written to slot idx.
  - If idx==3 or in_last=1: out_count=idx+1, state→HOLD, idx→0.
  - Otherwise idx increments.
- HOLD, out_valid & out_ready:
  - group_cnt increments, wrapping from all-ones to 0.
  - All slots are cleared to 0.
  - If a word is accepted in the same cycle, it is written to x, and the other slots become 0.
  - If that word has in_last=1, the state stays HOLD with out_count=1.
  - Otherwise idx→1 and state→COLLECT.
  - If no word is accepted, idx→0 and state→COLLECT.
- HOLD, out_ready=0: x, y, z, w, out_count and out_valid hold their values. in_ready=0, so no word is accepted.
- Unfilled slots of a short group are always 0, so downstream final_sum equals the sum of the real operands.
- in_last with idx==3 is equivalent to a normal fourth word.
- in_data and in_last are ignored when the handshake does not complete.
- Reset (rst_n low, any time, including mid-group or in HOLD):
  - state=COLLECT, idx=0.
  - x=y=z=w=0, out_count=0, group_cnt=0, out_valid=0.
  - in_ready is forced to 0 while rst_n is low.
  - A partial group in progress is discarded.

## Timing
- Latency: the fourth or last word is accepted at edge N; out_valid=1 from just after edge N. The downstream combinational sum is valid in the same cycle.
- Throughput: one word per cycle sustained with out_ready held high. The group release and the first word of the next group share one cycle, so there are no bubbles.
- Output registers are x, y, z, w, out_valid, out_count and group_cnt; all change only on clk edges or on asynchronous reset.
- Combinational paths: only out_ready→in_ready, active in HOLD.
- Reset release: in_ready=1 in the first cycle rst_n is high.

## Test plan
- Reset mid-group: accept 0x11 and 0x22, then pull rst_n low for 1 cycle → out_valid=0, x..w=0, out_count=0, group_cnt=0. The next four words 0x3, 0xA, 0x1, 0x2 form a fresh group → x=3, y=A, z=1, w=2, count=4, downstream sum 0x10.
- Streaming with no bubbles:
  - Stimulus: in_valid and out_ready held high; words AAAAAAAA, 55555555, AAAAAAAA, 55555555, FFFFFFFF, 00000001, 00000000, 00000000 on consecutive cycles.
  - Required: 8 words accepted in 8 cycles and in_ready never low.
  - Required: group 1 sum = 0x1FFFFFFFE, group 2 sum = 0x100000000, group_cnt=2.
- Backpressure: complete the group 1, 2, 3, 4, then hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, x..w stable at 1..4, no word taken. Raising out_ready releases the group, and the pending word lands in x in that same cycle.
- Short group: send FFFFFFFF, then 00000001 with in_last=1 → x=FFFFFFFF, y=1, z=0, w=0, out_count=2, sum 0x100000000.
- Single-word groups back-to-back: with out_ready=1, send three words each with in_last=1 → out_valid stays high for 3 cycles, out_count=1 each cycle, z=w=0 throughout.
- Counter wrap: with CNT_W=2, hand off 5 groups → group_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/operand_collector_4x32.sv
// operand_collector_4x32
// Groups a serial stream of words into four operand slots (x, y, z, w) for the
// 4x32 multi-operand adder. A group closes after the fourth word or after a
// word flagged in_last, and unused slots are zero so the downstream sum counts
// only the real operands. The group release and the first word of the next
// group can share one cycle, so streaming runs without bubbles.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer keeps valid (and its data)
// stable until the transfer. ready is allowed to depend combinationally on the
// other side's ready only on the path out_ready -> in_ready while a group is
// held. Data and last presented without a completed transfer are ignored.
module operand_collector_4x32 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] z,
    output logic [DATA_W-1:0] w,
    output logic [2:0]        out_count,
    output logic [CNT_W-1:0]  group_cnt,
    output logic              dbg_state
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] idx;
    logic       accept;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // While collecting we always take a word; while holding, a word can only
    // enter in the same cycle the held group leaves. Held low during reset.
    assign in_ready  = rst_n & ((state == COLLECT) | out_ready);
    assign accept    = in_valid & in_ready;
    assign dbg_state = state;

    // Collector FSM: fills slots, presents complete groups, clears on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= 2'd0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            w         <= '0;
            out_count <= 3'd0;
            out_valid <= 1'b0;
            group_cnt <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        case (idx)
                            2'd0:    x <= in_data;
                            2'd1:    y <= in_data;
                            2'd2:    z <= in_data;
                            default: w <= in_data;
                        endcase
                        if (idx == 2'd3 || in_last) begin
                            out_count <= {1'b0, idx} + 3'd1;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                            idx       <= 2'd0;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        group_cnt <= group_cnt + CNT_ONE;
                        y         <= '0;
                        z         <= '0;
                        w         <= '0;
                        if (accept) begin
                            x <= in_data;
                            if (in_last) begin
                                // A one-word group goes straight back out.
                                out_count <= 3'd1;
                                idx       <= 2'd0;
                            end else begin
                                idx       <= 2'd1;
                                out_valid <= 1'b0;
                                state     <= COLLECT;
                            end
                        end else begin
                            x         <= '0;
                            idx       <= 2'd0;
                            out_valid <= 1'b0;
                            state     <= COLLECT;
                        end
                    end
                end
                default: begin
                    state     <= COLLECT;
                    out_valid <= 1'b0;
                    idx       <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_collector_4x32.sv
// Testbench for operand_collector_4x32: table-driven groups plus hand-written
// sequences for reset, streaming, backpressure, single-word groups and wrap.
module tb_operand_collector_4x32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, dbg_state;
    logic [31:0] x, y, z, w;
    logic [2:0]  out_count;
    logic [15:0] group_cnt;

    // Second instance with a 2-bit counter, sharing all inputs
    logic        in_ready2, out_valid2, dbg_state2;
    logic [31:0] x2, y2, z2, w2;
    logic [2:0]  out_count2;
    logic [1:0]  group_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    logic [33:0] exp_q[$];

    typedef struct {
        int          n;
        logic        last;
        logic [31:0] d [4];
        logic [31:0] e [4];
        logic [2:0]  exp_cnt;
        logic [33:0] exp_sum;
    } vec_t;

    vec_t vecs [8];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    operand_collector_4x32 #(.DATA_W(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .x(x), .y(y), .z(z), .w(w),
        .out_count(out_count), .group_cnt(group_cnt), .dbg_state(dbg_state)
    );

    operand_collector_4x32 #(.DATA_W(32), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .x(x2), .y(y2), .z(z2), .w(w2),
        .out_count(out_count2), .group_cnt(group_cnt2), .dbg_state(dbg_state2)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] dut_sum();
        return {2'b00, x} + {2'b00, y} + {2'b00, z} + {2'b00, w};
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Present one word and wait (bounded) for it to be accepted.
    task automatic send_word(input logic [31:0] d, input logic l);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (in_ready) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_word_timeout: word %0h not accepted within 20 cycles", d);
        end
    endtask

    task automatic set_vec(input int i, input int n, input logic last,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3,
                           input logic [2:0] cnt, input logic [33:0] sum);
        vecs[i].n = n;
        vecs[i].last = last;
        vecs[i].d[0] = d0; vecs[i].d[1] = d1; vecs[i].d[2] = d2; vecs[i].d[3] = d3;
        vecs[i].e[0] = e0; vecs[i].e[1] = e1; vecs[i].e[2] = e2; vecs[i].e[3] = e3;
        vecs[i].exp_cnt = cnt;
        vecs[i].exp_sum = sum;
    endtask

    // ---------------- main test ----------------
    initial begin
        int acc, lows, highs;
        logic [33:0] es;
        logic [1:0] wrap_exp [5];
        logic [31:0] stream [8];

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        set_vec(0, 4, 1'b0, 32'h3, 32'hA, 32'h1, 32'h2,
                32'h3, 32'hA, 32'h1, 32'h2, 3'd4, 34'h10);
        set_vec(1, 4, 1'b0, 32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'h55555555,
                32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'h55555555, 3'd4, 34'h1FFFFFFFE);
        set_vec(2, 2, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0,
                32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 3'd2, 34'h100000000);
        set_vec(3, 3, 1'b1, 32'h7, 32'h8, 32'h9, 32'h0,
                32'h7, 32'h8, 32'h9, 32'h0, 3'd3, 34'h18);
        set_vec(4, 1, 1'b1, 32'h12345678, 32'h0, 32'h0, 32'h0,
                32'h12345678, 32'h0, 32'h0, 32'h0, 3'd1, 34'h12345678);
        set_vec(5, 4, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0,
                32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 3'd4, 34'h100000000);
        set_vec(6, 4, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4,
                32'h1, 32'h2, 32'h3, 32'h4, 3'd4, 34'hA);
        set_vec(7, 2, 1'b1, 32'hDEADBEEF, 32'h21524111, 32'h0, 32'h0,
                32'hDEADBEEF, 32'h21524111, 32'h0, 32'h0, 3'd2, 34'h100000000);

        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        stream[0] = 32'hAAAAAAAA; stream[1] = 32'h55555555;
        stream[2] = 32'hAAAAAAAA; stream[3] = 32'h55555555;
        stream[4] = 32'hFFFFFFFF; stream[5] = 32'h00000001;
        stream[6] = 32'h00000000; stream[7] = 32'h00000000;

        // ---- reset mid-group ----
        #2;
        rst_n = 1'b0;
        #1;
        check("rst0_in_ready", in_ready, 0);
        check("rst0_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst0_release_in_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b1;
        send_word(32'h1, 1'b0); send_word(32'h2, 1'b0);
        send_word(32'h3, 1'b0); send_word(32'h4, 1'b0);
        check("pre_hold_out_count", out_count, 4);
        send_word(32'h11, 1'b0);
        send_word(32'h22, 1'b0);
        check("mid_group_cnt", group_cnt, 1);
        check("mid_y", y, 32'h22);
        check("mid_out_valid", out_valid, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_x", x, 0);
        check("midrst_y", y, 0);
        check("midrst_out_count", out_count, 0);
        check("midrst_group_cnt", group_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_release_in_ready", in_ready, 1);
        send_word(32'h3, 1'b0); send_word(32'hA, 1'b0);
        send_word(32'h1, 1'b0); send_word(32'h2, 1'b0);
        check("fresh_valid", out_valid, 1);
        check("fresh_x", x, 32'h3);
        check("fresh_y", y, 32'hA);
        check("fresh_z", z, 32'h1);
        check("fresh_w", w, 32'h2);
        check("fresh_count", out_count, 4);
        check("fresh_sum", dut_sum(), 34'h10);

        // ---- table-driven groups, out_ready held high ----
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(vecs[i].exp_sum);
            for (int j = 0; j < vecs[i].n; j++)
                send_word(vecs[i].d[j], vecs[i].last && (j == vecs[i].n - 1));
            es = exp_q.pop_front();
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_x", i), x, vecs[i].e[0]);
            check($sformatf("vec%0d_y", i), y, vecs[i].e[1]);
            check($sformatf("vec%0d_z", i), z, vecs[i].e[2]);
            check($sformatf("vec%0d_w", i), w, vecs[i].e[3]);
            check($sformatf("vec%0d_count", i), out_count, vecs[i].exp_cnt);
            check($sformatf("vec%0d_sum", i), dut_sum(), es);
            check($sformatf("vec%0d_group_cnt", i), group_cnt, i);
        end

        // ---- streaming with no bubbles ----
        do_reset();
        out_ready = 1'b1;
        acc  = 0;
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = stream[i];
            in_last  = 1'b0;
            #1;
            if (in_ready) acc++;
            else lows++;
            @(posedge clk);
            @(negedge clk);
            if (i == 3) begin
                check("stream_g1_valid", out_valid, 1);
                check("stream_g1_sum", dut_sum(), 34'h1FFFFFFFE);
            end
            if (i == 7) begin
                check("stream_g2_valid", out_valid, 1);
                check("stream_g2_sum", dut_sum(), 34'h100000000);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("stream_accepted", acc, 8);
        check("stream_ready_lows", lows, 0);
        check("stream_group_cnt", group_cnt, 2);
        check("stream_drained", out_valid, 0);

        // ---- backpressure ----
        do_reset();
        out_ready = 1'b1;
        send_word(32'h1, 1'b0); send_word(32'h2, 1'b0);
        send_word(32'h3, 1'b0); send_word(32'h4, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h99;
        highs     = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (in_ready) highs++;
            @(posedge clk);
            @(negedge clk);
        end
        check("bp_in_ready_highs", highs, 0);
        check("bp_x", x, 32'h1);
        check("bp_y", y, 32'h2);
        check("bp_z", z, 32'h3);
        check("bp_w", w, 32'h4);
        check("bp_count", out_count, 4);
        check("bp_valid", out_valid, 1);
        check("bp_group_cnt", group_cnt, 0);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_pending_x", x, 32'h99);
        check("bp_pending_y", y, 0);
        check("bp_pending_w", w, 0);
        check("bp_after_valid", out_valid, 0);
        check("bp_after_group_cnt", group_cnt, 1);

        // ---- single-word groups back-to-back ----
        do_reset();
        out_ready = 1'b1;
        send_word(32'h5, 1'b0); send_word(32'h6, 1'b0);
        send_word(32'h7, 1'b0); send_word(32'h8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            send_word(32'h100 + k, 1'b1);
            check($sformatf("single%0d_valid", k), out_valid, 1);
            check($sformatf("single%0d_count", k), out_count, 1);
            check($sformatf("single%0d_x", k), x, 32'h100 + k);
            check($sformatf("single%0d_y", k), y, 0);
            check($sformatf("single%0d_z", k), z, 0);
            check($sformatf("single%0d_w", k), w, 0);
        end

        // ---- counter wrap on the 2-bit instance ----
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            send_word(32'h40 + k, 1'b1);
            if (k >= 1) begin
                check($sformatf("wrap%0d_cnt2", k), group_cnt2, wrap_exp[k-1]);
                check($sformatf("wrap%0d_cnt16", k), group_cnt, k);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
